// File: rtl/composite_sync_generator_if.sv
// composite_sync_generator_if: sample strobe, pixel pull handshake and video/timing outputs
interface composite_sync_generator_if;
  logic        sample_valid;
  logic        en;
  logic [11:0] pixel_data;
  logic        pixel_req;
  logic [11:0] video_out;
  logic        line_start;
  logic        frame_start;
  logic [11:0] h_cnt;
  logic [8:0]  line_cnt;
  modport master (
    output sample_valid, en, pixel_data,
    input  pixel_req, video_out, line_start, frame_start, h_cnt, line_cnt
  );
  modport slave (
    input  sample_valid, en, pixel_data,
    output pixel_req, video_out, line_start, frame_start, h_cnt, line_cnt
  );
endinterface

// File: rtl/composite_sync_generator.sv
// composite_sync_generator: 12-bit composite video stream with hsync, porches, active video
// and broad vsync lines, advancing one sample per sample_valid strobe.
module composite_sync_generator #(
  parameter logic [11:0] SYNC_LEVEL      = 12'd2000,
  parameter logic [11:0] BLANK_LEVEL     = 12'd3000,
  parameter logic [11:0] LINE_LEN        = 12'd2360,
  parameter logic [11:0] HSYNC_WIDTH     = 12'd173,
  parameter logic [11:0] BACK_PORCH      = 12'd175,
  parameter logic [11:0] ACTIVE_WIDTH    = 12'd1920,
  parameter logic [11:0] VSYNC_LOW_WIDTH = 12'd2187,
  parameter logic [8:0]  VSYNC_LINES     = 9'd3,
  parameter logic [8:0]  VBLANK_LINES    = 9'd20,
  parameter logic [8:0]  LINES_PER_FIELD = 9'd262
) (
  input logic clk,
  input logic rst_n,
  composite_sync_generator_if.slave bus
);
  localparam logic [11:0] ACT_START = HSYNC_WIDTH + BACK_PORCH;
  localparam logic [11:0] ACT_END   = ACT_START + ACTIVE_WIDTH;
  typedef enum logic {IDLE, RUN} state_t;
  state_t      state, state_nxt;
  logic        go, broad, active, h_wrap;
  logic        line_start_nxt, frame_start_nxt;
  logic [11:0] h_nxt, video_nxt;
  logic [8:0]  line_nxt;
  logic [12:0] luma_sum;
  assign go       = state == RUN && bus.en;
  assign broad    = bus.line_cnt < VSYNC_LINES;
  assign active   = bus.line_cnt >= VBLANK_LINES && bus.h_cnt >= ACT_START && bus.h_cnt < ACT_END;
  assign h_wrap   = bus.h_cnt == LINE_LEN - 12'd1;
  assign luma_sum = {1'b0, BLANK_LEVEL} + {3'b000, bus.pixel_data[11:2]};
  assign bus.pixel_req = go && active;
  always_comb begin
    state_nxt       = bus.en ? RUN : IDLE;
    h_nxt           = '0;
    line_nxt        = '0;
    video_nxt       = BLANK_LEVEL;
    line_start_nxt  = 1'b0;
    frame_start_nxt = 1'b0;
    if (go) begin
      h_nxt           = h_wrap ? '0 : bus.h_cnt + 12'd1;
      line_nxt        = !h_wrap ? bus.line_cnt :
                        bus.line_cnt == LINES_PER_FIELD - 9'd1 ? '0 : bus.line_cnt + 9'd1;
      line_start_nxt  = bus.h_cnt == '0;
      frame_start_nxt = bus.h_cnt == '0 && bus.line_cnt == '0;
      // luma is added on top of blank and clipped to the DAC full scale
      video_nxt       = broad ? (bus.h_cnt < VSYNC_LOW_WIDTH ? SYNC_LEVEL : BLANK_LEVEL) :
                        bus.h_cnt < HSYNC_WIDTH ? SYNC_LEVEL :
                        active ? (luma_sum[12] ? 12'hFFF : luma_sum[11:0]) : BLANK_LEVEL;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      bus.h_cnt       <= '0;
      bus.line_cnt    <= '0;
      bus.video_out   <= BLANK_LEVEL;
      bus.line_start  <= 1'b0;
      bus.frame_start <= 1'b0;
    end else if (bus.sample_valid) begin
      state           <= state_nxt;
      bus.h_cnt       <= h_nxt;
      bus.line_cnt    <= line_nxt;
      bus.video_out   <= video_nxt;
      bus.line_start  <= line_start_nxt;
      bus.frame_start <= frame_start_nxt;
    end
  end
endmodule

// File: tb/tb_composite_sync_generator.sv
// tb_composite_sync_generator: randomized checks of two scaled-down generators (blank 3000 and 3500)
// against a sample-index model of the composite line/field format.
module tb_composite_sync_generator;
  localparam int L = 48, HS = 6, BP = 5, AW = 30, VLOW = 40, VSL = 3, VBL = 5, F = 12;
  localparam logic [11:0] SYNC = 12'd2000;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  composite_sync_generator_if b0 (), b1 ();
  assign b1.sample_valid = b0.sample_valid;
  assign b1.en           = b0.en;
  assign b1.pixel_data   = b0.pixel_data;
  composite_sync_generator #(
    .BLANK_LEVEL(12'd3000), .LINE_LEN(12'd48), .HSYNC_WIDTH(12'd6), .BACK_PORCH(12'd5),
    .ACTIVE_WIDTH(12'd30), .VSYNC_LOW_WIDTH(12'd40), .VSYNC_LINES(9'd3), .VBLANK_LINES(9'd5),
    .LINES_PER_FIELD(9'd12)
  ) dut0 (.clk(clk), .rst_n(rst_n), .bus(b0.slave));
  composite_sync_generator #(
    .BLANK_LEVEL(12'd3500), .LINE_LEN(12'd48), .HSYNC_WIDTH(12'd6), .BACK_PORCH(12'd5),
    .ACTIVE_WIDTH(12'd30), .VSYNC_LOW_WIDTH(12'd40), .VSYNC_LINES(9'd3), .VBLANK_LINES(9'd5),
    .LINES_PER_FIELD(9'd12)
  ) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));
  logic [34:0] o0, o1;
  assign o0 = {b0.video_out, b0.line_start, b0.frame_start, b0.h_cnt, b0.line_cnt};
  assign o1 = {b1.video_out, b1.line_start, b1.frame_start, b1.h_cnt, b1.line_cnt};
  int n_chk = 0, n_fail = 0;
  // model: p is the index of the next sample to process within the field
  int p;
  bit mrun, els, efs;
  logic [11:0] ev0, ev1;
  logic [1:0] pr, epr;
  function automatic bit act(input int q);
    return q / L >= VBL && q % L >= HS + BP && q % L < HS + BP + AW;
  endfunction
  function automatic logic [11:0] level(input int q, input int blank, input int pd);
    int h = q % L, l = q / L, s = blank + pd / 4;
    if (l < VSL) return h < VLOW ? SYNC : 12'(blank);
    if (h < HS) return SYNC;
    if (act(q)) return 12'(s > 4095 ? 4095 : s);
    return 12'(blank);
  endfunction
  function automatic logic [34:0] ev_vec(input logic [11:0] v);
    return {v, els, efs, 12'(p % L), 9'(p / L)};
  endfunction
  task automatic model_reset();
    mrun = 0; p = 0; els = 0; efs = 0; ev0 = 12'd3000; ev1 = 12'd3500;
  endtask
  task automatic tick(input bit sv);
    b0.sample_valid = sv;
    #1;
    pr  = {b0.pixel_req, b1.pixel_req};
    epr = (mrun && b0.en && act(p)) ? 2'b11 : 2'b00;
    @(posedge clk);
    if (sv) begin
      if (!mrun || !b0.en) begin
        ev0 = 12'd3000; ev1 = 12'd3500; els = 0; efs = 0; p = 0;
        mrun = !mrun && b0.en;
      end else begin
        ev0 = level(p, 3000, int'(b0.pixel_data));
        ev1 = level(p, 3500, int'(b0.pixel_data));
        els = p % L == 0; efs = p == 0;
        p = (p + 1) % (L * F);
      end
    end
    #1;
  endtask
  task automatic test_reset();
    b0.sample_valid = 0; b0.en = 0; b0.pixel_data = '0; rst_n = 0;
    #12;
    n_chk++; if (o0 !== {12'd3000, 23'd0}) begin n_fail++; $display("FAIL reset dut0 got %h exp %h", o0, {12'd3000, 23'd0}); end
    n_chk++; if (o1 !== {12'd3500, 23'd0}) begin n_fail++; $display("FAIL reset dut1 got %h exp %h", o1, {12'd3500, 23'd0}); end
    n_chk++; if ({b0.pixel_req, b1.pixel_req} !== 2'b00) begin n_fail++; $display("FAIL reset pixel_req got %b exp 00", {b0.pixel_req, b1.pixel_req}); end
    @(negedge clk); rst_n = 1; model_reset();
    @(posedge clk); #1;
  endtask
  task automatic test_idle();
    b0.en = 0;
    for (int i = 0; i < 100; i++) begin
      b0.pixel_data = 12'($urandom);
      tick(1);
      n_chk++; if (o0 !== {12'd3000, 23'd0}) begin n_fail++; $display("FAIL idle dut0 got %h exp %h", o0, {12'd3000, 23'd0}); end
      n_chk++; if (o1 !== {12'd3500, 23'd0}) begin n_fail++; $display("FAIL idle dut1 got %h exp %h", o1, {12'd3500, 23'd0}); end
      n_chk++; if (pr !== 2'b00) begin n_fail++; $display("FAIL idle pixel_req got %b exp 00", pr); end
    end
  endtask
  task automatic test_frame();
    int n = 0, req = 0, syn = 0;
    bit seen = 0;
    b0.en = 1;
    for (int i = 0; i < 2 * L * F + 10; i++) begin
      b0.pixel_data = 12'($urandom);
      tick(1);
      n++; req += int'(pr[1]);
      n_chk++; if (o0 !== ev_vec(ev0)) begin n_fail++; $display("FAIL frame dut0 got %h exp %h", o0, ev_vec(ev0)); end
      n_chk++; if (o1 !== ev_vec(ev1)) begin n_fail++; $display("FAIL frame dut1 got %h exp %h", o1, ev_vec(ev1)); end
      n_chk++; if (pr !== epr) begin n_fail++; $display("FAIL frame pixel_req got %b exp %b", pr, epr); end
      if (b0.frame_start) begin
        if (seen) begin
          n_chk++; if (n != L * F) begin n_fail++; $display("FAIL frame_period got %0d exp %0d", n, L * F); end
          n_chk++; if (req != (F - VBL) * AW) begin n_fail++; $display("FAIL req_count got %0d exp %0d", req, (F - VBL) * AW); end
          n_chk++; if (syn != VSL * VLOW + (F - VSL) * HS) begin n_fail++; $display("FAIL sync_count got %0d exp %0d", syn, VSL * VLOW + (F - VSL) * HS); end
        end
        seen = 1; n = 0; req = 0; syn = 0;
      end
      syn += int'(b0.video_out == SYNC);
    end
    n_chk++; if (!seen) begin n_fail++; $display("FAIL frame_seen got 0 exp 1"); end
  endtask
  task automatic test_saturation();
    int c0 = 0, c1 = 0;
    b0.en = 1; b0.pixel_data = 12'hFFF;
    for (int i = 0; i < L * F; i++) begin
      tick(1);
      c0 += int'(b0.video_out == 12'd4023);
      c1 += int'(b1.video_out == 12'd4095);
      n_chk++; if (o1 !== ev_vec(ev1)) begin n_fail++; $display("FAIL sat_hi dut1 got %h exp %h", o1, ev_vec(ev1)); end
    end
    n_chk++; if (c0 != (F - VBL) * AW) begin n_fail++; $display("FAIL sat_4023_count got %0d exp %0d", c0, (F - VBL) * AW); end
    n_chk++; if (c1 != (F - VBL) * AW) begin n_fail++; $display("FAIL sat_4095_count got %0d exp %0d", c1, (F - VBL) * AW); end
    b0.pixel_data = 12'h000; c1 = 0;
    for (int i = 0; i < L * F; i++) begin
      tick(1);
      c1 += int'(b1.video_out == 12'd4095);
      n_chk++; if (o1 !== ev_vec(ev1)) begin n_fail++; $display("FAIL sat_lo dut1 got %h exp %h", o1, ev_vec(ev1)); end
      n_chk++; if (o0 !== ev_vec(ev0)) begin n_fail++; $display("FAIL sat_lo dut0 got %h exp %h", o0, ev_vec(ev0)); end
    end
    n_chk++; if (c1 != 0) begin n_fail++; $display("FAIL sat_zero_count got %0d exp 0", c1); end
  endtask
  task automatic test_gaps();
    b0.en = 1;
    for (int i = 0; i < 3 * L * F; i++) begin
      b0.pixel_data = 12'($urandom);
      tick(i % 2 == 0 && $urandom_range(0, 3) != 0);
      n_chk++; if (o0 !== ev_vec(ev0)) begin n_fail++; $display("FAIL gaps dut0 got %h exp %h", o0, ev_vec(ev0)); end
      n_chk++; if (o1 !== ev_vec(ev1)) begin n_fail++; $display("FAIL gaps dut1 got %h exp %h", o1, ev_vec(ev1)); end
      n_chk++; if (pr !== epr) begin n_fail++; $display("FAIL gaps pixel_req got %b exp %b", pr, epr); end
    end
  endtask
  task automatic run_to(input int target, input string name);
    int k = 0;
    while (p != target && k < 2 * L * F) begin
      b0.pixel_data = 12'($urandom);
      tick(1);
      k++;
    end
    n_chk++; if (p != target) begin n_fail++; $display("FAIL %s timeout got %0d exp %0d", name, p, target); end
  endtask
  task automatic test_abort();
    b0.en = 1;
    run_to(7 * L + 20, "abort_seek");
    b0.en = 0;
    tick(1);
    n_chk++; if (pr !== 2'b00) begin n_fail++; $display("FAIL abort pixel_req got %b exp 00", pr); end
    n_chk++; if (o0 !== {12'd3000, 23'd0}) begin n_fail++; $display("FAIL abort dut0 got %h exp %h", o0, {12'd3000, 23'd0}); end
    n_chk++; if (o1 !== {12'd3500, 23'd0}) begin n_fail++; $display("FAIL abort dut1 got %h exp %h", o1, {12'd3500, 23'd0}); end
    b0.en = 1;
    tick(1);
    n_chk++; if (o0 !== {12'd3000, 23'd0}) begin n_fail++; $display("FAIL reenable dut0 got %h exp %h", o0, {12'd3000, 23'd0}); end
    tick(1);
    n_chk++; if (o0 !== {SYNC, 2'b11, 12'd1, 9'd0}) begin n_fail++; $display("FAIL restart dut0 got %h exp %h", o0, {SYNC, 2'b11, 12'd1, 9'd0}); end
    n_chk++; if (o0 !== ev_vec(ev0)) begin n_fail++; $display("FAIL restart_model dut0 got %h exp %h", o0, ev_vec(ev0)); end
  endtask
  task automatic test_reset_mid();
    b0.en = 1;
    run_to(6 * L + HS + BP + 5, "rst_seek");
    n_chk++; if ({b0.pixel_req, b1.pixel_req} !== 2'b11) begin n_fail++; $display("FAIL rst_pre pixel_req got %b exp 11", {b0.pixel_req, b1.pixel_req}); end
    rst_n = 0;
    #1;
    n_chk++; if ({b0.pixel_req, b1.pixel_req} !== 2'b00) begin n_fail++; $display("FAIL rst_mid pixel_req got %b exp 00", {b0.pixel_req, b1.pixel_req}); end
    n_chk++; if (o0 !== {12'd3000, 23'd0}) begin n_fail++; $display("FAIL rst_mid dut0 got %h exp %h", o0, {12'd3000, 23'd0}); end
    n_chk++; if (o1 !== {12'd3500, 23'd0}) begin n_fail++; $display("FAIL rst_mid dut1 got %h exp %h", o1, {12'd3500, 23'd0}); end
    #1 rst_n = 1; model_reset();
    for (int i = 0; i < 2 * L; i++) begin
      b0.pixel_data = 12'($urandom);
      tick(1);
      n_chk++; if (o0 !== ev_vec(ev0)) begin n_fail++; $display("FAIL rst_after dut0 got %h exp %h", o0, ev_vec(ev0)); end
      n_chk++; if (pr !== epr) begin n_fail++; $display("FAIL rst_after pixel_req got %b exp %b", pr, epr); end
    end
  endtask
  initial begin
    test_reset();
    test_idle();
    test_frame();
    test_saturation();
    test_gaps();
    test_abort();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/composite_sync_generator.md
Name: composite_sync_generator

Overview:
- Generates a 12-bit composite video sample stream (sync tips, porches, active video, broad vertical-sync pulses) for the video DAC, one sample per sample_valid strobe at 36.9 MHz.
- It is the transmit-side counterpart of the input sync separator, and its default timing is chosen so that separator detects its HSync, VSync and back porch.
- Pixel luma is pulled from an upstream source with a request strobe.
- Used for loopback self-test and for analog output.

Parameters:
- SYNC_LEVEL, 2000: DAC code for the sync tip. Must be below the separator's 2850 threshold.
- BLANK_LEVEL, 3000: DAC code for the blank/black level.
- LINE_LEN, 2360: samples per line (~63.9 us).
- HSYNC_WIDTH, 173: sync-tip samples on normal lines (~4.7 us).
- BACK_PORCH, 175: samples from the sync rising edge to the first active sample.
- ACTIVE_WIDTH, 1920: active samples per line. Requires HSYNC_WIDTH + BACK_PORCH + ACTIVE_WIDTH <= LINE_LEN.
- VSYNC_LOW_WIDTH, 2187: sync-tip samples on broad (vsync) lines. Must be > 800 and < LINE_LEN.
- VSYNC_LINES, 3: broad-pulse lines at the start of each field.
- VBLANK_LINES, 20: lines, counted from field start, that carry no active video. Must be >= VSYNC_LINES.
- LINES_PER_FIELD, 262: lines per field.

Ports:
- clk  in  1  system clock (73.8 MHz)
- rst_n  in  1  asynchronous active-low reset
- sample_valid  in  1  DAC sample strobe; all state advances only on cycles where it is 1
- en  in  1  generator enable; 0 forces idle
- pixel_data  in  12  luma for the current active sample; valid when pixel_req=1
- pixel_req  out  1  combinational: current sample is active video
- video_out  out  12  registered DAC code
- line_start  out  1  one-strobe pulse marking h_cnt=0
- frame_start  out  1  one-strobe pulse marking h_cnt=0 with line_cnt=0
- h_cnt  out  12  current sample index within the line
- line_cnt  out  9  current line index within the field

Behaviour:
Reset (rst_n=0, asynchronous):
- h_cnt=0, line_cnt=0, video_out=BLANK_LEVEL, line_start=0, frame_start=0, internal running flag=0.

Strobe gating:
- On cycles with sample_valid=0, all registers hold.
- pixel_req remains a pure decode of the counters and en.

Idle (running=0):
- On each strobe: video_out<=BLANK_LEVEL, h_cnt<=0, line_cnt<=0, no pulses.
- On a strobe with en=1: running<=1. The next strobe processes h_cnt=0, line_cnt=0.

Run (running=1), on each strobe:
- Counters: h_cnt wraps at LINE_LEN-1 to 0. On wrap, line_cnt increments and wraps at LINES_PER_FIELD-1 to 0.
- Broad line (line_cnt < VSYNC_LINES): video_out<=SYNC_LEVEL when h_cnt < VSYNC_LOW_WIDTH, else BLANK_LEVEL. No pixel_req.
- Normal line, sync: h_cnt < HSYNC_WIDTH gives SYNC_LEVEL.
- Normal line, active window: HSYNC_WIDTH+BACK_PORCH <= h_cnt < HSYNC_WIDTH+BACK_PORCH+ACTIVE_WIDTH, with line_cnt >= VBLANK_LINES.
  - pixel_req=1.
  - video_out <= min(BLANK_LEVEL + pixel_data[11:2], 4095), computed at 13 bits and saturated.
- Normal line, otherwise: BLANK_LEVEL. This covers the back porch, the front porch, and lines below VBLANK_LINES.
- Pulses: line_start<=1 on the strobe processing h_cnt=0, and frame_start<=1 additionally when line_cnt=0. Both are cleared on the next strobe.
- Latency: video_out, line_start and frame_start reflect the processed counter value one clk after that strobe. The counter then advances in the same edge.

pixel_req / pixel_data handshake:
- pixel_req=1 only while running, en=1, and the counters are in the active window of an active line.
- pixel_data is sampled on the clk edge where sample_valid & pixel_req.
- Exactly ACTIVE_WIDTH requests per active line. No backpressure.

Enable deassert while running:
- Takes effect on the next strobe: running<=0, counters to 0, video_out<=BLANK_LEVEL.
- Abort mid-line or mid-field is immediate. No partial-line completion.
- Re-enable restarts at frame_start.

Reset mid-operation:
- Asynchronously returns to reset values. pixel_req drops to 0 immediately.

Test Plan:
- Reset then hold en=0, sample_valid=1 for 100 strobes -> video_out=3000 throughout, pixel_req=0, no pulses.
- en=1, pixel_data=12'hFFF, run to line 20 -> video_out=2000 for exactly 173 strobes, then 3000 for 175, then 4023 for 1920 with 1920 pixel_req, then 3000 for 92. Line period is 2360 strobes.
- Lines 0-2 -> 2187 consecutive 2000 samples then 173 of 3000. Lines 3-19 carry hsync only, with pixel_req=0. frame_start occurs every 262*2360 = 618320 strobes.
- Saturation: BLANK_LEVEL=3500, pixel_data=12'hFFF -> video_out=4095. pixel_data=0 -> video_out=3500.
- sample_valid asserted every 2nd clk with random extra gaps -> same sample sequence as the continuous case. Counters and outputs hold during gaps.
- Deassert en at line 50, h_cnt=1000 -> next strobe video_out=3000, counters 0. Reassert -> frame_start on the first processed strobe. Pulsing rst_n mid-active-line forces reset values asynchronously.
